// File: rtl/switch_port_tx.sv
// switch_port_tx: host-side packet transmitter for one ingress port of the
// 4-port switch. Packets offered over a valid/ready handshake are queued in a
// small FIFO and emitted as single-cycle valid_in strobes. Each emitted packet
// is followed by GAP_CYCLES idle cycles.
//
// Optional feature macro: SWITCH_TX_TARGET_CHECK_EN
//   Defined   - packets whose target is zero, not one-hot, or equal to PORT_ID
//               are discarded at pop time and counted in drop_count.
//   Undefined - every packet is emitted unchanged and drop_count is tied to 0.
module switch_port_tx #(
    parameter int                DATA_W     = 8,
    parameter int                ADDR_W     = 4,
    parameter logic [ADDR_W-1:0] PORT_ID    = ADDR_W'(1),
    parameter int                FIFO_DEPTH = 4,
    parameter int                GAP_CYCLES = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          host_valid,
    output logic                          host_ready,
    input  logic [ADDR_W-1:0]             host_target,
    input  logic [DATA_W-1:0]             host_data,
    output logic                          valid_in,
    output logic [ADDR_W-1:0]             source_in,
    output logic [ADDR_W-1:0]             target_in,
    output logic [DATA_W-1:0]             data_in,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   sent_count,
    output logic [15:0]                   drop_count
);

    localparam int                PTR_W    = $clog2(FIFO_DEPTH);
    localparam int                LVL_W    = PTR_W + 1;
    localparam logic [LVL_W-1:0]  LVL_FULL = LVL_W'(FIFO_DEPTH);
    localparam logic [3:0]        GAP_INIT = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] target;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t             r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [LVL_W-1:0]   r_level;
    logic               r_full;
    state_t             r_state;
    state_t             w_next_state;
    logic [3:0]         r_gap_cnt;
    logic               r_valid;
    logic [ADDR_W-1:0]  r_source;
    logic [ADDR_W-1:0]  r_target;
    logic [DATA_W-1:0]  r_data;
    logic [15:0]        r_sent_cnt;

    entry_t             w_head;
    logic               w_push;
    logic               w_empty;
    logic               w_pop_slot;
    logic               w_pop;
    logic               w_drop;
    logic               w_emit;
    logic [LVL_W-1:0]   w_level_next;

    // host_ready comes from the registered full flag only: a pop that frees a
    // slot while full is not visible to the host until the next cycle.
    assign w_push       = host_valid && !r_full;
    assign w_empty      = (r_level == '0);
    assign w_head       = r_mem[r_rd_ptr];
    assign w_level_next = r_level + LVL_W'(w_push) - LVL_W'(w_pop);

    // A pop opportunity exists in IDLE, on the last GAP cycle (so the gap is
    // exactly GAP_CYCLES long), and in SEND when back-to-back is allowed.
    assign w_pop_slot = (r_state == S_IDLE)
                     || ((r_state == S_SEND) && (GAP_CYCLES == 0))
                     || ((r_state == S_GAP)  && (r_gap_cnt == 4'd0));
    assign w_pop      = w_pop_slot && !w_empty;

`ifdef SWITCH_TX_TARGET_CHECK_EN
    function automatic logic target_ok(input logic [ADDR_W-1:0] t);
        return (t != '0) && ((t & (t - ADDR_W'(1))) == '0) && (t != PORT_ID);
    endfunction

    logic [15:0] r_drop_cnt;

    assign w_drop = w_pop && !target_ok(w_head.target);

    // Count packets discarded at pop time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign drop_count = r_drop_cnt;
`else
    assign w_drop     = 1'b0;
    assign drop_count = '0;
`endif

    assign w_emit = w_pop && !w_drop;

    // FSM state register.
    // NOTE: sequential blocks use non-blocking (<=) so every register samples
    // pre-edge values; blocking (=) here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state: an emitted pop always lands in SEND; otherwise SEND
    // moves on to GAP (or IDLE) and GAP expires into IDLE.
    // NOTE: the default assignment first means every path assigns
    // w_next_state, so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        if (w_emit) begin
            w_next_state = S_SEND;
        end else begin
            case (r_state)
                S_IDLE:  w_next_state = S_IDLE;
                S_SEND:  w_next_state = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
                S_GAP:   if (r_gap_cnt == 4'd0) w_next_state = S_IDLE;
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    // Gap counter: loaded on SEND->GAP, then counts down to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gap_cnt <= 4'd0;
        end else if ((r_state == S_SEND) && (w_next_state == S_GAP)) begin
            r_gap_cnt <= GAP_INIT;
        end else if ((r_state == S_GAP) && (r_gap_cnt != 4'd0)) begin
            r_gap_cnt <= r_gap_cnt - 4'd1;
        end
    end

    // FIFO storage write port.
    // NOTE: the packet array is deliberately not reset; pointers and level
    // define which entries are valid, so clearing the data is unnecessary.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= '{target: host_target, data: host_data};
        end
    end

    // FIFO pointers, occupancy and registered full flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_level <= w_level_next;
            r_full  <= (w_level_next == LVL_FULL);
        end
    end

    // Output registers: load on emit, hold otherwise; strobe lasts one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_source <= PORT_ID;
            r_target <= '0;
            r_data   <= '0;
        end else begin
            r_valid <= w_emit;
            if (w_emit) begin
                r_source <= PORT_ID;
                r_target <= w_head.target;
                r_data   <= w_head.data;
            end
        end
    end

    // Count a packet once its strobe cycle completes, so a reset during the
    // strobe leaves it uncounted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sent_cnt <= '0;
        end else if (r_valid) begin
            r_sent_cnt <= r_sent_cnt + 16'd1;
        end
    end

    assign host_ready = !r_full;
    assign valid_in   = r_valid;
    assign source_in  = r_source;
    assign target_in  = r_target;
    assign data_in    = r_data;
    assign fifo_level = r_level;
    assign sent_count = r_sent_cnt;

endmodule

// File: tb/tb_switch_port_tx.sv
// Bench for switch_port_tx: instance A uses GAP_CYCLES=1, instance B uses
// GAP_CYCLES=0. Table-driven fill/drain vectors, hand sequences for latency,
// back-to-back, reset and target filtering, then randomized traffic against
// an edge-scheduling reference model.
module tb_switch_port_tx;

    localparam int         DEPTH = 4;
    localparam logic [3:0] PID   = 4'b0001;

    logic       clk = 1'b0;
    logic       rst;
    logic       hv_a, hv_b;
    logic [3:0] h_tgt;
    logic [7:0] h_dat;

    logic        a_ready, a_valid, b_ready, b_valid;
    logic [3:0]  a_src, a_tgt, b_src, b_tgt;
    logic [7:0]  a_dat, b_dat;
    logic [2:0]  a_lvl, b_lvl;
    logic [15:0] a_sent, a_drop, b_sent, b_drop;

    always #5 clk = ~clk;

    switch_port_tx #(.GAP_CYCLES(1)) u_a (
        .clk(clk), .rst(rst), .host_valid(hv_a), .host_ready(a_ready),
        .host_target(h_tgt), .host_data(h_dat), .valid_in(a_valid),
        .source_in(a_src), .target_in(a_tgt), .data_in(a_dat),
        .fifo_level(a_lvl), .sent_count(a_sent), .drop_count(a_drop)
    );

    switch_port_tx #(.GAP_CYCLES(0)) u_b (
        .clk(clk), .rst(rst), .host_valid(hv_b), .host_ready(b_ready),
        .host_target(h_tgt), .host_data(h_dat), .valid_in(b_valid),
        .source_in(b_src), .target_in(b_tgt), .data_in(b_dat),
        .fifo_level(b_lvl), .sent_count(b_sent), .drop_count(b_drop)
    );

    // Selected-instance view used by the random phase.
    logic        sel;
    logic        m_valid, m_ready;
    logic [3:0]  m_src, m_tgt;
    logic [7:0]  m_dat;
    logic [2:0]  m_lvl;
    logic [15:0] m_sent, m_drop;
    assign m_valid = sel ? b_valid : a_valid;
    assign m_ready = sel ? b_ready : a_ready;
    assign m_src   = sel ? b_src   : a_src;
    assign m_tgt   = sel ? b_tgt   : a_tgt;
    assign m_dat   = sel ? b_dat   : a_dat;
    assign m_lvl   = sel ? b_lvl   : a_lvl;
    assign m_sent  = sel ? b_sent  : a_sent;
    assign m_drop  = sel ? b_drop  : a_drop;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        hv_a = 1'b0;
        hv_b = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic bit is_dropped(input logic [3:0] t);
`ifdef SWITCH_TX_TARGET_CHECK_EN
        return ($countones(t) != 1) || (t == PID);
`else
        return 1'b0;
`endif
    endfunction

    // Table record: inputs before an edge, expected outputs after it.
    typedef struct {
        logic       hv;
        logic [3:0] tgt;
        logic [7:0] dat;
        logic       ev;
        logic [3:0] etgt;
        logic [7:0] edat;
        int         elvl;
        logic       erdy;
        int         esent;
    } vec_t;

    typedef struct {
        logic [3:0] t;
        logic [7:0] d;
    } pkt_t;

    vec_t tbl[16];

    // Reference model state: packets waiting, and the earliest edge at which
    // the next packet may be emitted.
    pkt_t mq[$];
    pkt_t last_pkt;
    int   t_now, next_free, model_gap, exp_sent, exp_drop;
    logic exp_v, have_last;

    initial begin
        int base_sent;
        int pulses;
        logic [3:0] seen_tgt;
        logic [3:0] tgts[4];
        int exp_pulses, exp_drops;
        logic [3:0] exp_last_tgt;

        // Fill with pushes while host_valid stays high (GAP_CYCLES=1), then drain.
        tbl[0]  = '{1'b1, 4'b0010, 8'h11, 1'b0, 4'h0,    8'h00, 1, 1'b1, 0};
        tbl[1]  = '{1'b1, 4'b0100, 8'h22, 1'b1, 4'b0010, 8'h11, 1, 1'b1, 0};
        tbl[2]  = '{1'b1, 4'b1000, 8'h33, 1'b0, 4'h0,    8'h00, 2, 1'b1, 1};
        tbl[3]  = '{1'b1, 4'b0010, 8'h44, 1'b1, 4'b0100, 8'h22, 2, 1'b1, 1};
        tbl[4]  = '{1'b1, 4'b0100, 8'h55, 1'b0, 4'h0,    8'h00, 3, 1'b1, 2};
        tbl[5]  = '{1'b1, 4'b1000, 8'h66, 1'b1, 4'b1000, 8'h33, 3, 1'b1, 2};
        tbl[6]  = '{1'b1, 4'b0010, 8'h77, 1'b0, 4'h0,    8'h00, 4, 1'b0, 3};
        tbl[7]  = '{1'b1, 4'b0100, 8'h88, 1'b1, 4'b0010, 8'h44, 3, 1'b1, 3};
        tbl[8]  = '{1'b0, 4'b0000, 8'h00, 1'b0, 4'h0,    8'h00, 3, 1'b1, 4};
        tbl[9]  = '{1'b0, 4'b0000, 8'h00, 1'b1, 4'b0100, 8'h55, 2, 1'b1, 4};
        tbl[10] = '{1'b0, 4'b0000, 8'h00, 1'b0, 4'h0,    8'h00, 2, 1'b1, 5};
        tbl[11] = '{1'b0, 4'b0000, 8'h00, 1'b1, 4'b1000, 8'h66, 1, 1'b1, 5};
        tbl[12] = '{1'b0, 4'b0000, 8'h00, 1'b0, 4'h0,    8'h00, 1, 1'b1, 6};
        tbl[13] = '{1'b0, 4'b0000, 8'h00, 1'b1, 4'b0010, 8'h77, 0, 1'b1, 6};
        tbl[14] = '{1'b0, 4'b0000, 8'h00, 1'b0, 4'h0,    8'h00, 0, 1'b1, 7};
        tbl[15] = '{1'b0, 4'b0000, 8'h00, 1'b0, 4'h0,    8'h00, 0, 1'b1, 7};

        sel   = 1'b0;
        h_tgt = '0;
        h_dat = '0;
        do_reset();

        // Reset state of both instances.
        check("rst_a_valid", a_valid, 0);
        check("rst_a_src",   a_src,   PID);
        check("rst_a_tgt",   a_tgt,   0);
        check("rst_a_dat",   a_dat,   0);
        check("rst_a_lvl",   a_lvl,   0);
        check("rst_a_ready", a_ready, 1);
        check("rst_a_sent",  a_sent,  0);
        check("rst_a_drop",  a_drop,  0);
        check("rst_b_valid", b_valid, 0);
        check("rst_b_lvl",   b_lvl,   0);
        check("rst_b_ready", b_ready, 1);

        // Single push: strobe only between edges k+1 and k+2.
        h_tgt = 4'b0100; h_dat = 8'hA5; hv_a = 1'b1;
        tick();
        hv_a = 1'b0;
        check("single_k_valid", a_valid, 0);
        check("single_k_lvl",   a_lvl,   1);
        tick();
        check("single_k1_valid", a_valid, 1);
        check("single_k1_src",   a_src,   PID);
        check("single_k1_tgt",   a_tgt,   4'b0100);
        check("single_k1_dat",   a_dat,   8'hA5);
        check("single_k1_lvl",   a_lvl,   0);
        tick();
        check("single_k2_valid", a_valid, 0);
        check("single_k2_sent",  a_sent,  1);
        repeat (2) tick();

        // Table-driven fill and drain on instance A.
        base_sent = 1;
        for (int i = 0; i < 16; i++) begin
            hv_a  = tbl[i].hv;
            h_tgt = tbl[i].tgt;
            h_dat = tbl[i].dat;
            tick();
            check($sformatf("tbl%0d_valid", i), a_valid, tbl[i].ev);
            check($sformatf("tbl%0d_lvl", i),   a_lvl,   tbl[i].elvl);
            check($sformatf("tbl%0d_ready", i), a_ready, tbl[i].erdy);
            check($sformatf("tbl%0d_sent", i),  a_sent,  base_sent + tbl[i].esent);
            if (tbl[i].ev) begin
                check($sformatf("tbl%0d_src", i), a_src, PID);
                check($sformatf("tbl%0d_tgt", i), a_tgt, tbl[i].etgt);
                check($sformatf("tbl%0d_dat", i), a_dat, tbl[i].edat);
            end
        end
        hv_a = 1'b0;

        // Back-to-back on instance B (GAP_CYCLES=0): three consecutive strobes.
        for (int i = 0; i < 5; i++) begin
            hv_b  = (i < 3);
            h_tgt = 4'b0010 << i;
            h_dat = 8'h31 + 8'(i);
            tick();
            check($sformatf("b2b%0d_valid", i), b_valid, (i >= 1 && i <= 3));
            check($sformatf("b2b%0d_lvl", i),   b_lvl,   (i <= 2) ? 1 : 0);
            check($sformatf("b2b%0d_sent", i),  b_sent,  (i >= 2) ? i - 1 : 0);
            if (i >= 1 && i <= 3) check($sformatf("b2b%0d_dat", i), b_dat, 8'h30 + 8'(i));
        end
        hv_b = 1'b0;

        // Target filtering (or its absence) on instance A.
`ifdef SWITCH_TX_TARGET_CHECK_EN
        tgts = '{4'b0001, 4'b0000, 4'b0011, 4'b1000};
        exp_pulses = 1; exp_drops = 3; exp_last_tgt = 4'b1000;
`else
        tgts = '{4'b0000, 4'b0011, 4'b1000, 4'b0001};
        exp_pulses = 4; exp_drops = 0; exp_last_tgt = 4'b0001;
`endif
        pulses = 0;
        seen_tgt = 4'hF;
        for (int i = 0; i < 14; i++) begin
            hv_a  = (i < 4);
            h_tgt = tgts[i % 4];
            h_dat = 8'hD0 + 8'(i);
            tick();
            if (a_valid) begin
                pulses++;
                seen_tgt = a_tgt;
            end
        end
        hv_a = 1'b0;
        check("tchk_pulses", pulses,   exp_pulses);
        check("tchk_target", seen_tgt, exp_last_tgt);
        check("tchk_drop",   a_drop,   exp_drops);
        check("tchk_sent",   a_sent,   base_sent + 7 + exp_pulses);

        // Reset mid-burst: strobe high with two entries queued.
        for (int i = 0; i < 4; i++) begin
            hv_a  = 1'b1;
            h_tgt = 4'b0100;
            h_dat = 8'hE1 + 8'(i);
            tick();
        end
        hv_a = 1'b0;
        check("mid_pre_valid", a_valid, 1);
        check("mid_pre_dat",   a_dat,   8'hE2);
        check("mid_pre_lvl",   a_lvl,   2);
        #2 rst = 1'b1;
        #1;
        check("mid_async_valid", a_valid, 0);
        check("mid_async_lvl",   a_lvl,   0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("mid_post_ready", a_ready, 1);
        check("mid_post_sent",  a_sent,  0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (a_valid || a_lvl != 0) pulses++;
        end
        check("mid_quiet", pulses, 0);

        // Randomized traffic on each instance against the reference model.
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            do_reset();
            model_gap = (s == 0) ? 1 : 0;
            mq.delete();
            t_now = 0; next_free = 0; exp_sent = 0; exp_drop = 0;
            exp_v = 1'b0; have_last = 1'b0;
            for (int c = 0; c < 700; c++) begin
                logic hv;
                logic acc;
                pkt_t p;
                hv    = ($urandom_range(0, 99) < ((c < 350) ? 55 : 92));
                h_tgt = 4'($urandom_range(0, 15));
                h_dat = 8'($urandom_range(0, 255));
                hv_a  = hv && (s == 0);
                hv_b  = hv && (s == 1);
                tick();
                acc = hv && (mq.size() < DEPTH);
                exp_sent += int'(exp_v);
                exp_v = 1'b0;
                if (mq.size() > 0 && t_now >= next_free) begin
                    p = mq.pop_front();
                    if (is_dropped(p.t)) begin
                        exp_drop++;
                        next_free = t_now + 1;
                    end else begin
                        exp_v     = 1'b1;
                        last_pkt  = p;
                        have_last = 1'b1;
                        next_free = t_now + 1 + model_gap;
                    end
                end
                if (acc) mq.push_back('{t: h_tgt, d: h_dat});
                t_now++;
                check("rnd_valid", m_valid, exp_v);
                check("rnd_lvl",   m_lvl,   mq.size());
                check("rnd_ready", m_ready, mq.size() < DEPTH);
                check("rnd_sent",  m_sent,  exp_sent);
                check("rnd_drop",  m_drop,  exp_drop);
                if (have_last) begin
                    check("rnd_src", m_src, PID);
                    check("rnd_tgt", m_tgt, last_pkt.t);
                    check("rnd_dat", m_dat, last_pkt.d);
                end
            end
            hv_a = 1'b0;
            hv_b = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
